pipelined_mips_decode_stage: RTL and testbench

- Registered decode/issue stage between IF/ID and EX of the pipelined MIPS core.
- Decodes a generalised instruction set into a control bundle held in a one-entry output register.
- Valid/ready handshakes on both sides.
- Per-register pending-write scoreboard: stalls RAW hazards and caps WAW depth until writeback retires each write.

---
 rtl/pipelined_mips_decode_stage_pkg.sv | 92 +++++++++
 rtl/pipelined_mips_decode_stage_scoreboard.sv | 73 +++++++
 rtl/pipelined_mips_decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_mips_decode_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_mips_decode_stage_pkg.sv
// Shared definitions for the MIPS decode/issue stage: control-bundle layout,
// ALU / operand / write-back encodings and instruction opcode/funct values.
package pipelined_mips_decode_stage_pkg;

    localparam int unsigned MIPS_REG_FIELD_WIDTH = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLL = 4'b0011,
        ALU_SRL = 4'b0100,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        REGISTER_OUTPUT_2 = 2'd0,
        IMMEDIATE         = 2'd1,
        SHIFT_IMMEDIATE   = 2'd2
    } alu_b_source_e;

    typedef enum logic [1:0] {
        WDS_ALU       = 2'd0,
        WDS_MEM       = 2'd1,
        WDS_PC_PLUS_4 = 2'd2
    } write_data_source_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [4:0] LINK_REGISTER = 5'd31;

    // Declared MSB first; flattens onto o_control_signals bit-for-bit.
    typedef struct packed {
        logic                            is_jump;
        logic                            is_link;
        logic                            is_branch;
        logic                            branch_on_ne;
        logic                            illegal;
        logic [MIPS_REG_FIELD_WIDTH-1:0] rd;
        logic [MIPS_REG_FIELD_WIDTH-1:0] rt;
        logic [MIPS_REG_FIELD_WIDTH-1:0] rs;
        logic [MIPS_REG_FIELD_WIDTH-1:0] dest_addr;
        logic                            uses_rs;
        logic                            uses_rt;
        write_data_source_e              reg_write_data_source;
        logic                            reg_write_enable;
        logic                            mem_write_enable;
        alu_ctrl_e                       alu_ctrl;
        alu_b_source_e                   alu_b_source;
    } mips_control_t;

    localparam int unsigned MIPS_CONTROL_SIGNALS_WIDTH = $bits(mips_control_t);

    localparam int unsigned ALU_B_SOURCE_LSB          = 0;
    localparam int unsigned ALU_CTRL_LSB              = 2;
    localparam int unsigned MEM_WRITE_ENABLE_BIT      = 6;
    localparam int unsigned REG_WRITE_ENABLE_BIT      = 7;
    localparam int unsigned REG_WRITE_DATA_SOURCE_LSB = 8;
    localparam int unsigned USES_RT_BIT               = 10;
    localparam int unsigned USES_RS_BIT               = 11;
    localparam int unsigned DEST_ADDR_LSB             = 12;
    localparam int unsigned RS_LSB                    = 17;
    localparam int unsigned RT_LSB                    = 22;
    localparam int unsigned RD_LSB                    = 27;
    localparam int unsigned ILLEGAL_BIT               = 32;
    localparam int unsigned BRANCH_ON_NE_BIT          = 33;
    localparam int unsigned IS_BRANCH_BIT             = 34;
    localparam int unsigned IS_LINK_BIT               = 35;
    localparam int unsigned IS_JUMP_BIT               = 36;

endpackage

// File: rtl/pipelined_mips_decode_stage_scoreboard.sv
// Per-register pending-write counters: +1 when a writing bundle leaves for EX,
// -1 when writeback retires it. Register 0 is never tracked.
module mips_scoreboard #(
    parameter int unsigned SCOREBOARD_DEPTH = 3,
    parameter int unsigned NUM_REGS         = 32,
    localparam int unsigned ADDR_W          = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inc_valid_i,
    input  logic [ADDR_W-1:0] inc_addr_i,
    input  logic              dec_valid_i,
    input  logic [ADDR_W-1:0] dec_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    output logic              dest_full_o
);

    localparam int unsigned CNT_W = $clog2(SCOREBOARD_DEPTH + 1);
    localparam int unsigned PND_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    logic             rs_inc_hit;
    logic             rt_inc_hit;
    logic             dest_inc_hit;
    logic [PND_W-1:0] dest_pending;

    // A bundle leaving this cycle counts as in flight already.
    assign rs_inc_hit   = inc_valid_i && (inc_addr_i == rs_addr_i);
    assign rt_inc_hit   = inc_valid_i && (inc_addr_i == rt_addr_i);
    assign dest_inc_hit = inc_valid_i && (inc_addr_i == dest_addr_i);

    assign rs_busy_o = (rs_addr_i != '0) && ((cnt_q[rs_addr_i] != '0) || rs_inc_hit);
    assign rt_busy_o = (rt_addr_i != '0) && ((cnt_q[rt_addr_i] != '0) || rt_inc_hit);

    assign dest_pending = {1'b0, cnt_q[dest_addr_i]} + PND_W'(dest_inc_hit);
    assign dest_full_o  = (dest_addr_i != '0) && (dest_pending >= PND_W'(SCOREBOARD_DEPTH));

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                // A retire against an empty counter is dropped, so only a live
                // decrement can cancel a same-cycle increment.
                if (inc_valid_i && (inc_addr_i == ADDR_W'(r))) begin
                    if (!(dec_valid_i && (dec_addr_i == ADDR_W'(r)) && (cnt_q[r] != '0))
                        && (cnt_q[r] != CNT_W'(SCOREBOARD_DEPTH)))
                        cnt_d[r] = cnt_q[r] + 1'b1;
                end else if (dec_valid_i && (dec_addr_i == ADDR_W'(r)) && (cnt_q[r] != '0)) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                cnt_q[r] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    wb_on_zero_count: assert property (@(posedge clk_i) disable iff (rst_i)
        (dec_valid_i && (dec_addr_i != '0)) |-> (cnt_q[dec_addr_i] != '0));

endmodule

// File: rtl/pipelined_mips_decode_stage.sv
// Registered decode/issue stage between IF/ID and EX: decodes into a one-entry
// control-bundle register, stalling on RAW hazards and WAW depth via a scoreboard.
module pipelined_mips_decode_stage
    import pipelined_mips_decode_stage_pkg::*;
#(
    parameter int unsigned SCOREBOARD_DEPTH      = 3,
    parameter int unsigned NUM_REGS              = 32,
    parameter bit          ENABLE_SHIFT_VARIABLE = 1'b1,
    localparam int unsigned ADDR_W               = $clog2(NUM_REGS)
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic [31:0]                           i_instruction,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    output logic [MIPS_CONTROL_SIGNALS_WIDTH-1:0] o_control_signals,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic                                  o_illegal,
    input  logic                                  i_flush,
    input  logic                                  i_wb_valid,
    input  logic [ADDR_W-1:0]                     i_wb_addr
);

    mips_control_t dec;
    mips_control_t ctrl_q, ctrl_d;
    logic          valid_q, valid_d;
    logic          illegal_q, illegal_d;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_shamt_imm;

    logic handoff;
    logic load;
    logic hazard;
    logic rs_busy, rt_busy, dest_full;

    assign opcode           = i_instruction[31:26];
    assign funct            = i_instruction[5:0];
    assign unused_shamt_imm = ^i_instruction[10:6];

    always_comb begin
        dec         = '0;
        dec.rs      = i_instruction[25:21];
        dec.rt      = i_instruction[20:16];
        dec.rd      = i_instruction[15:11];
        case (opcode)
            OP_RTYPE: begin
                dec.uses_rs          = 1'b1;
                dec.uses_rt          = 1'b1;
                dec.reg_write_enable = 1'b1;
                dec.dest_addr        = dec.rd;
                dec.alu_b_source     = REGISTER_OUTPUT_2;
                case (funct)
                    FN_ADD: dec.alu_ctrl = ALU_ADD;
                    FN_SUB: dec.alu_ctrl = ALU_SUB;
                    FN_AND: dec.alu_ctrl = ALU_AND;
                    FN_OR:  dec.alu_ctrl = ALU_OR;
                    FN_SLT: dec.alu_ctrl = ALU_SLT;
                    FN_SLL, FN_SRL: begin
                        dec.alu_ctrl     = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                        dec.uses_rs      = 1'b0;
                        dec.alu_b_source = SHIFT_IMMEDIATE;
                    end
                    FN_SLLV, FN_SRLV: begin
                        if (ENABLE_SHIFT_VARIABLE)
                            dec.alu_ctrl = (funct == FN_SLLV) ? ALU_SLL : ALU_SRL;
                        else
                            dec.illegal = 1'b1;
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                dec.uses_rs          = 1'b1;
                dec.reg_write_enable = 1'b1;
                dec.dest_addr        = dec.rt;
                dec.alu_b_source     = IMMEDIATE;
                case (opcode)
                    OP_SLTI: dec.alu_ctrl = ALU_SLT;
                    OP_ANDI: dec.alu_ctrl = ALU_AND;
                    OP_ORI:  dec.alu_ctrl = ALU_OR;
                    default: dec.alu_ctrl = ALU_ADD;
                endcase
                if (opcode == OP_LW)
                    dec.reg_write_data_source = WDS_MEM;
            end
            OP_SW: begin
                dec.uses_rs          = 1'b1;
                dec.uses_rt          = 1'b1;
                dec.mem_write_enable = 1'b1;
                dec.alu_ctrl         = ALU_ADD;
                dec.alu_b_source     = IMMEDIATE;
            end
            OP_BEQ, OP_BNE: begin
                dec.uses_rs      = 1'b1;
                dec.uses_rt      = 1'b1;
                dec.is_branch    = 1'b1;
                dec.branch_on_ne = (opcode == OP_BNE);
                dec.alu_ctrl     = ALU_SUB;
            end
            OP_J: dec.is_jump = 1'b1;
            OP_JAL: begin
                dec.is_jump               = 1'b1;
                dec.is_link               = 1'b1;
                dec.reg_write_enable      = 1'b1;
                dec.dest_addr             = LINK_REGISTER;
                dec.reg_write_data_source = WDS_PC_PLUS_4;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal words keep only the raw register fields, so they never stall or write.
        if (dec.illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec.rs      = i_instruction[25:21];
            dec.rt      = i_instruction[20:16];
            dec.rd      = i_instruction[15:11];
        end
    end

    mips_scoreboard #(
        .SCOREBOARD_DEPTH(SCOREBOARD_DEPTH),
        .NUM_REGS        (NUM_REGS)
    ) u_sb (
        .clk_i      (i_clk),
        .rst_i      (i_reset),
        .inc_valid_i(handoff && ctrl_q.reg_write_enable),
        .inc_addr_i (ADDR_W'(ctrl_q.dest_addr)),
        .dec_valid_i(i_wb_valid),
        .dec_addr_i (i_wb_addr),
        .rs_addr_i  (ADDR_W'(dec.rs)),
        .rt_addr_i  (ADDR_W'(dec.rt)),
        .dest_addr_i(ADDR_W'(dec.dest_addr)),
        .rs_busy_o  (rs_busy),
        .rt_busy_o  (rt_busy),
        .dest_full_o(dest_full)
    );

    assign hazard  = (dec.uses_rs && rs_busy) || (dec.uses_rt && rt_busy)
                   || (dec.reg_write_enable && dest_full);
    assign handoff = valid_q && i_ready && !i_flush;
    assign o_ready = !hazard && (!valid_q || i_ready) && !i_flush;
    assign load    = i_valid && o_ready;

    always_comb begin
        valid_d   = valid_q;
        illegal_d = illegal_q;
        ctrl_d    = ctrl_q;
        if (i_flush) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end else if (load) begin
            valid_d   = 1'b1;
            illegal_d = dec.illegal;
            ctrl_d    = dec;
        end else if (handoff) begin
            valid_d   = 1'b0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign o_valid           = valid_q;
    assign o_illegal         = illegal_q;
    assign o_control_signals = ctrl_q;

endmodule

// File: tb/tb_pipelined_mips_decode_stage.sv
// Directed bench for the decode/issue stage: a decode table plus hand-written
// handshake, hazard, flush and reset sequences.
module tb_pipelined_mips_decode_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_instruction;
    logic        i_valid;
    logic        o_ready;
    logic [36:0] o_control_signals;
    logic        o_valid;
    logic        i_ready;
    logic        o_illegal;
    logic        i_flush;
    logic        i_wb_valid;
    logic [4:0]  i_wb_addr;

    int checks = 0;
    int errors = 0;

    pipelined_mips_decode_stage dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_instruction    (i_instruction),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .o_control_signals(o_control_signals),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_illegal        (o_illegal),
        .i_flush          (i_flush),
        .i_wb_valid       (i_wb_valid),
        .i_wb_addr        (i_wb_addr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic        jump, link, br, bne, ill;
        logic [4:0]  dest;
        logic        urs, urt;
        logic [1:0]  wds;
        logic        rwe, mwe;
        logic [3:0]  alu;
        logic [1:0]  alub;
    } vec_t;

    vec_t vq[$];

    function automatic logic [36:0] pack(input vec_t v);
        logic [31:0] ins;
        ins = v.instr;
        return {v.jump, v.link, v.br, v.bne, v.ill, ins[15:11], ins[20:16], ins[25:21],
                v.dest, v.urs, v.urt, v.wds, v.rwe, v.mwe, v.alu, v.alub};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic int cnt_total();
        int t;
        t = 0;
        for (int r = 0; r < 32; r++) t += int'(dut.u_sb.cnt_q[r]);
        return t;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //                 instr        j  l  b  ne il dest  rs rt wds rwe mwe alu   alub
        vq.push_back(vec_t'{32'h00221820, 0, 0, 0, 0, 0, 5'd3,  1, 1, 2'd0, 1, 0, 4'd2, 2'd0}); // add
        vq.push_back(vec_t'{32'h00A13022, 0, 0, 0, 0, 0, 5'd6,  1, 1, 2'd0, 1, 0, 4'd6, 2'd0}); // sub
        vq.push_back(vec_t'{32'h01093824, 0, 0, 0, 0, 0, 5'd7,  1, 1, 2'd0, 1, 0, 4'd0, 2'd0}); // and
        vq.push_back(vec_t'{32'h016C5025, 0, 0, 0, 0, 0, 5'd10, 1, 1, 2'd0, 1, 0, 4'd1, 2'd0}); // or
        vq.push_back(vec_t'{32'h01CF682A, 0, 0, 0, 0, 0, 5'd13, 1, 1, 2'd0, 1, 0, 4'd7, 2'd0}); // slt
        vq.push_back(vec_t'{32'h00031100, 0, 0, 0, 0, 0, 5'd2,  0, 1, 2'd0, 1, 0, 4'd3, 2'd2}); // sll
        vq.push_back(vec_t'{32'h00052042, 0, 0, 0, 0, 0, 5'd4,  0, 1, 2'd0, 1, 0, 4'd4, 2'd2}); // srl
        vq.push_back(vec_t'{32'h01073004, 0, 0, 0, 0, 0, 5'd6,  1, 1, 2'd0, 1, 0, 4'd3, 2'd0}); // sllv
        vq.push_back(vec_t'{32'h01073006, 0, 0, 0, 0, 0, 5'd6,  1, 1, 2'd0, 1, 0, 4'd4, 2'd0}); // srlv
        vq.push_back(vec_t'{32'h20050007, 0, 0, 0, 0, 0, 5'd5,  1, 0, 2'd0, 1, 0, 4'd2, 2'd1}); // addi
        vq.push_back(vec_t'{32'h304100FF, 0, 0, 0, 0, 0, 5'd1,  1, 0, 2'd0, 1, 0, 4'd0, 2'd1}); // andi
        vq.push_back(vec_t'{32'h34830010, 0, 0, 0, 0, 0, 5'd3,  1, 0, 2'd0, 1, 0, 4'd1, 2'd1}); // ori
        vq.push_back(vec_t'{32'h28E6FFFF, 0, 0, 0, 0, 0, 5'd6,  1, 0, 2'd0, 1, 0, 4'd7, 2'd1}); // slti
        vq.push_back(vec_t'{32'h8FA70004, 0, 0, 0, 0, 0, 5'd7,  1, 0, 2'd1, 1, 0, 4'd2, 2'd1}); // lw
        vq.push_back(vec_t'{32'hAFA80008, 0, 0, 0, 0, 0, 5'd0,  1, 1, 2'd0, 0, 1, 4'd2, 2'd1}); // sw
        vq.push_back(vec_t'{32'h10220003, 0, 0, 1, 0, 0, 5'd0,  1, 1, 2'd0, 0, 0, 4'd6, 2'd0}); // beq
        vq.push_back(vec_t'{32'h14220003, 0, 0, 1, 1, 0, 5'd0,  1, 1, 2'd0, 0, 0, 4'd6, 2'd0}); // bne
        vq.push_back(vec_t'{32'h08000010, 1, 0, 0, 0, 0, 5'd0,  0, 0, 2'd0, 0, 0, 4'd0, 2'd0}); // j
        vq.push_back(vec_t'{32'h0C000010, 1, 1, 0, 0, 0, 5'd31, 0, 0, 2'd2, 1, 0, 4'd0, 2'd0}); // jal
        vq.push_back(vec_t'{32'hFC221820, 0, 0, 0, 0, 1, 5'd0,  0, 0, 2'd0, 0, 0, 4'd0, 2'd0}); // bad opcode
        vq.push_back(vec_t'{32'h0022183F, 0, 0, 0, 0, 1, 5'd0,  0, 0, 2'd0, 0, 0, 4'd0, 2'd0}); // bad funct

        i_reset = 1'b1; i_instruction = '0; i_valid = 1'b0; i_ready = 1'b0;
        i_flush = 1'b0; i_wb_valid = 1'b0; i_wb_addr = '0;
        #12;
        check("reset_valid", o_valid, 0);
        check("reset_illegal", o_illegal, 0);
        check("reset_ctrl", o_control_signals, 0);
        check("reset_counts", cnt_total(), 0);
        @(negedge i_clk); i_reset = 1'b0;
        tick();
        check("idle_ready", o_ready, 1);

        // Decode table: load with EX stalled, inspect, then flush away.
        foreach (vq[i]) begin
            i_instruction = vq[i].instr; i_valid = 1'b1; i_ready = 1'b0;
            #1 check($sformatf("tbl%0d_ready", i), o_ready, 1);
            tick();
            i_valid = 1'b0;
            check($sformatf("tbl%0d_valid", i), o_valid, 1);
            check($sformatf("tbl%0d_ctrl", i), o_control_signals, pack(vq[i]));
            check($sformatf("tbl%0d_illegal", i), o_illegal, vq[i].ill);
            i_flush = 1'b1; tick(); i_flush = 1'b0;
            check($sformatf("tbl%0d_flushed", i), o_valid, 0);
        end
        check("tbl_counts_zero", cnt_total(), 0);

        // add r3,r1,r2 issued and handed off.
        i_instruction = 32'h00221820; i_valid = 1'b1; i_ready = 1'b1;
        tick(); i_valid = 1'b0;
        check("add_valid", o_valid, 1);
        check("add_alu", o_control_signals[5:2], 4'b0010);
        check("add_dest", o_control_signals[16:12], 3);
        check("add_rwe", o_control_signals[7], 1);
        tick();
        check("add_cnt3", dut.u_sb.cnt_q[3], 1);
        check("add_valid_drop", o_valid, 0);
        i_wb_valid = 1'b1; i_wb_addr = 5'd3; tick(); i_wb_valid = 1'b0;
        check("add_retired", dut.u_sb.cnt_q[3], 0);

        // RAW: addi r5 then sub r6,r5,r1.
        i_instruction = 32'h20050007; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_instruction = 32'h00A13022;
        #1 check("raw_handoff_cycle", o_ready, 0);
        tick();
        check("raw_cnt5", dut.u_sb.cnt_q[5], 1);
        #1 check("raw_stall", o_ready, 0);
        tick();
        check("raw_stall2", o_ready, 0);
        i_wb_valid = 1'b1; i_wb_addr = 5'd5;
        #1 check("raw_wb_cycle", o_ready, 0);
        tick(); i_wb_valid = 1'b0;
        #1 check("raw_released", o_ready, 1);
        tick(); i_valid = 1'b0;
        check("raw_sub_loaded", o_valid, 1);
        tick();
        check("raw_cnt6", dut.u_sb.cnt_q[6], 1);
        i_wb_valid = 1'b1; i_wb_addr = 5'd6; tick(); i_wb_valid = 1'b0;

        // WAW cap with four addi r4.
        i_instruction = 32'h20040001; i_valid = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("waw_accept%0d", k), o_ready, 1);
            tick();
        end
        #1 check("waw_cap_pending", o_ready, 0);
        tick();
        check("waw_cnt4_full", dut.u_sb.cnt_q[4], 3);
        check("waw_valid_drop", o_valid, 0);
        #1 check("waw_stall", o_ready, 0);
        i_wb_valid = 1'b1; i_wb_addr = 5'd4;
        #1 check("waw_wb_cycle", o_ready, 0);
        tick(); i_wb_valid = 1'b0;
        check("waw_cnt4_after_wb", dut.u_sb.cnt_q[4], 2);
        #1 check("waw_released", o_ready, 1);
        tick(); i_valid = 1'b0;
        check("waw_fourth_loaded", o_valid, 1);
        tick();
        check("waw_cnt4_refull", dut.u_sb.cnt_q[4], 3);
        i_wb_valid = 1'b1; i_wb_addr = 5'd4; tick(); tick(); tick(); i_wb_valid = 1'b0;
        check("waw_drained", dut.u_sb.cnt_q[4], 0);

        // Flush a held lw r7, even with EX ready.
        i_instruction = 32'h8FA70004; i_valid = 1'b1; i_ready = 1'b0;
        tick();
        check("flush_lw_held", o_valid, 1);
        i_instruction = 32'h00221820; i_flush = 1'b1; i_ready = 1'b1;
        #1 check("flush_blocks_load", o_ready, 0);
        tick(); i_flush = 1'b0; i_ready = 1'b0;
        check("flush_valid", o_valid, 0);
        check("flush_cnt7", dut.u_sb.cnt_q[7], 0);
        #1 check("flush_ready_after", o_ready, 1);
        tick(); i_valid = 1'b0;
        check("flush_next_valid", o_valid, 1);
        check("flush_next_dest", o_control_signals[16:12], 3);
        i_flush = 1'b1; tick(); i_flush = 1'b0;

        // Illegal opcode handed off normally.
        i_instruction = 32'hFC000000; i_valid = 1'b1; i_ready = 1'b1;
        tick(); i_valid = 1'b0;
        check("ill_flag", o_illegal, 1);
        check("ill_enables", {o_control_signals[7:6], o_control_signals[11:10]}, 0);
        tick();
        check("ill_handed_off", o_valid, 0);
        check("ill_no_counts", cnt_total(), 0);

        // jal writes r31 from PC+4.
        i_instruction = 32'h0C000010; i_valid = 1'b1; i_ready = 1'b1;
        tick(); i_valid = 1'b0;
        check("jal_dest", o_control_signals[16:12], 31);
        check("jal_wds", o_control_signals[9:8], 2);
        check("jal_jump", o_control_signals[36], 1);
        tick();
        check("jal_cnt31", dut.u_sb.cnt_q[31], 1);
        i_wb_valid = 1'b1; i_wb_addr = 5'd31; tick(); i_wb_valid = 1'b0;
        check("jal_retired", dut.u_sb.cnt_q[31], 0);

        // Simultaneous handoff and writeback on r9, then async reset mid-stall.
        i_instruction = 32'h20090001; i_valid = 1'b1; i_ready = 1'b1;
        tick(); tick();
        check("sim_cnt9_pre", dut.u_sb.cnt_q[9], 1);
        i_instruction = 32'h01205020; i_wb_valid = 1'b1; i_wb_addr = 5'd9;
        #1 check("sim_consumer_stall", o_ready, 0);
        tick(); i_wb_valid = 1'b0;
        check("sim_cnt9_same", dut.u_sb.cnt_q[9], 1);
        #1 check("sim_consumer_still", o_ready, 0);
        i_instruction = 32'h200B0001; i_ready = 1'b0;
        tick(); i_valid = 1'b0;
        check("rst_pre_valid", o_valid, 1);
        #2 i_reset = 1'b1;
        #1;
        check("rst_async_valid", o_valid, 0);
        check("rst_async_ctrl", o_control_signals, 0);
        check("rst_async_cnt9", dut.u_sb.cnt_q[9], 0);
        check("rst_async_counts", cnt_total(), 0);
        @(negedge i_clk); i_reset = 1'b0;
        i_instruction = 32'h01205020;
        tick();
        check("rst_consumer_ready", o_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
